srt4_result_fix: RTL and testbench
==================================

SRT4_RESULT_FIX -- requirements
Module: srt4_result_fix

Interface
REQ-001 SHALL have clk, input, 1: sole clock; all state changes on its rising edge.
REQ-002 SHALL have rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-003 SHALL have beginSignal, input, 1: start pulse from the divider when its iterations end; sampled only in IDLE.
REQ-004 SHALL have qp, input, 8: positive quotient-digit accumulator (binary weight).
REQ-005 SHALL have qn, input, 8: negative quotient-digit accumulator (binary weight).
REQ-006 SHALL have rem, input, 9: final partial remainder, two's complement, still normalized.
REQ-007 SHALL have divisor, input, 8: normalized divisor, bit 7 = 1.
REQ-008 SHALL have shift_cnt, input, 3: left-shift count applied during normalization, 0..7.
REQ-009 SHALL have outbus, output, 8: quotient, then remainder.
REQ-010 SHALL have outValid, output, 1: high when outbus carries a result byte.
REQ-011 SHALL have endSignal, output, 1: one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states IDLE, SUB, CORR, DENORM, OUTQ, OUTR, DONE.
REQ-013 In IDLE with beginSignal=1 at a rising edge, SHALL register qp, qn, rem, divisor and shift_cnt, then go to SUB; inputs are don't-care afterwards.
REQ-014 In SUB, SHALL compute Q = qp - qn modulo 256, then go to CORR.
REQ-015 In CORR, if R[8]=1, SHALL set Q = Q - 1 and R = R + {0,divisor} (9-bit, modulo 512), otherwise hold both; then go to DENORM with cnt = shift_cnt.
REQ-016 In DENORM, if cnt=0 SHALL go to OUTQ, else SHALL shift R right logically one bit and decrement cnt; DENORM lasts shift_cnt+1 cycles.
REQ-017 In OUTQ, SHALL drive outbus=Q and outValid=1 for exactly one cycle; in OUTR, SHALL drive outbus=R[7:0] and outValid=1 for exactly one cycle.
REQ-018 In DONE, SHALL drive endSignal=1 for exactly one cycle, outValid=0, then return to IDLE.
REQ-019 Outside OUTQ/OUTR, SHALL drive outbus=0x00 and outValid=0; endSignal=0 outside DONE.
REQ-020 SHALL have a total latency of 5+shift_cnt cycles from the beginSignal edge to the OUTQ cycle and 7+shift_cnt cycles to the DONE cycle.
REQ-021 SHALL ignore beginSignal in every state other than IDLE, with no queuing.
REQ-022 When beginSignal=1 in the DONE cycle, SHALL ignore it; a new start is accepted from the first IDLE cycle.
REQ-023 SHALL apply no correction when rem=0 (R[8]=0); remainder output is 0.

Reset
REQ-024 When rst is asserted, SHALL go to IDLE immediately and clear Q, R, cnt and all registered inputs, with outbus=0x00, outValid=0 and endSignal=0.
REQ-025 When rst is asserted mid-operation, SHALL abort the operation, emitting no further outValid or endSignal; the first start is accepted on the first edge after release.

Structure
REQ-026 SHALL place state encoding, data width (8), remainder width (9) and shift-count width (3) in shared package srt4_pkg.
REQ-027 SHALL use one sub-module, srt4_adder9, a 9-bit add/sub time-shared by SUB and CORR.

Verification
REQ-028 The bench SHALL drive qp=0x10, qn=0x02, rem=0x060, divisor=0xE0, shift_cnt=5 and check OUTQ 0x0E, then OUTR 0x03, then endSignal, with OUTQ 10 cycles after start.
REQ-029 The bench SHALL drive qp=0x10, qn=0x01, rem=0x1E0, divisor=0xE0, shift_cnt=5 and check correction: OUTQ 0x0E, OUTR 0x06.
REQ-030 The bench SHALL drive qp=0x05, qn=0x00, rem=0x000, divisor=0x80, shift_cnt=0 and check OUTQ 0x05 at start+5, OUTR 0x00, endSignal at start+7.
REQ-031 The bench SHALL pulse beginSignal again in SUB and in DONE and check that only one result pair and one endSignal are produced.
REQ-032 The bench SHALL assert rst in DENORM and check that outputs are 0 immediately, no outValid appears, and a following start completes normally.
REQ-033 The bench SHALL drive qp=0x00, qn=0x01, rem=0x1FF, divisor=0xFF, shift_cnt=0 and check OUTQ 0xFE, OUTR 0xFE.

Source files
------------

// File: rtl/srt4_pkg.sv
// Shared widths and FSM state encoding for the SRT radix-4 result fix-up block.
package srt4_pkg;

    localparam int DATA_W  = 8;
    localparam int REM_W   = 9;
    localparam int CNT_W   = 3;
    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] S_SUB    = 3'd1;
    localparam logic [STATE_W-1:0] S_CORR   = 3'd2;
    localparam logic [STATE_W-1:0] S_DENORM = 3'd3;
    localparam logic [STATE_W-1:0] S_OUTQ   = 3'd4;
    localparam logic [STATE_W-1:0] S_OUTR   = 3'd5;
    localparam logic [STATE_W-1:0] S_DONE   = 3'd6;

endpackage

// File: rtl/srt4_adder9.sv
// 9-bit adder/subtractor shared between quotient assembly and remainder correction.
module srt4_adder9
    import srt4_pkg::*;
(
    input  logic [REM_W-1:0] a_i,
    input  logic [REM_W-1:0] b_i,
    input  logic             sub_i,
    output logic [REM_W-1:0] sum_o
);

    assign sum_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/srt4_result_fix.sv
// Turns the divider's redundant quotient and normalized remainder into a final
// quotient/remainder pair and streams them out one byte per cycle.
module srt4_result_fix
    import srt4_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              beginSignal,
    input  logic [DATA_W-1:0] qp,
    input  logic [DATA_W-1:0] qn,
    input  logic [REM_W-1:0]  rem,
    input  logic [DATA_W-1:0] divisor,
    input  logic [CNT_W-1:0]  shift_cnt,
    output logic [DATA_W-1:0] outbus,
    output logic              outValid,
    output logic              endSignal
);

    localparam logic [CNT_W-1:0]  CNT_ONE = 3'd1;
    localparam logic [DATA_W-1:0] Q_ONE   = 8'd1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [REM_W-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  qp_q, qp_d;
    logic [DATA_W-1:0]  qn_q, qn_d;
    logic [DATA_W-1:0]  div_q, div_d;
    logic [CNT_W-1:0]   sh_q, sh_d;

    logic [REM_W-1:0]   add_a, add_b, add_sum;
    logic               add_sub;

    srt4_adder9 u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sub_i (add_sub),
        .sum_o (add_sum)
    );

    // SUB forms qp - qn; every other state feeds the remainder correction R + divisor.
    always_comb begin
        if (state_q == S_SUB) begin
            add_a   = {1'b0, qp_q};
            add_b   = {1'b0, qn_q};
            add_sub = 1'b1;
        end else begin
            add_a   = r_q;
            add_b   = {1'b0, div_q};
            add_sub = 1'b0;
        end
    end

    // NOTE: every variable gets a hold default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        qp_d    = qp_q;
        qn_d    = qn_q;
        div_d   = div_q;
        sh_d    = sh_q;
        unique case (state_q)
            S_IDLE: begin
                if (beginSignal) begin
                    qp_d    = qp;
                    qn_d    = qn;
                    r_d     = rem;
                    div_d   = divisor;
                    sh_d    = shift_cnt;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                q_d     = add_sum[DATA_W-1:0];
                state_d = S_CORR;
            end
            S_CORR: begin
                // A negative partial remainder means the last digit overshot by one.
                if (r_q[REM_W-1]) begin
                    q_d = q_q - Q_ONE;
                    r_d = add_sum;
                end
                cnt_d   = sh_q;
                state_d = S_DENORM;
            end
            S_DENORM: begin
                if (cnt_q == '0) begin
                    state_d = S_OUTQ;
                end else begin
                    r_d   = r_q >> 1;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_OUTQ:  state_d = S_OUTR;
            S_OUTR:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            qp_q    <= '0;
            qn_q    <= '0;
            div_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            qp_q    <= qp_d;
            qn_q    <= qn_d;
            div_q   <= div_d;
            sh_q    <= sh_d;
        end
    end

    // Outputs decode straight from state, so an asynchronous reset clears them at once.
    always_comb begin
        outbus    = '0;
        outValid  = 1'b0;
        endSignal = 1'b0;
        unique case (state_q)
            S_OUTQ: begin
                outbus   = q_q;
                outValid = 1'b1;
            end
            S_OUTR: begin
                outbus   = r_q[DATA_W-1:0];
                outValid = 1'b1;
            end
            S_DONE:  endSignal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_srt4_result_fix.sv
// Randomized and directed checks of srt4_result_fix against an arithmetic model.
module tb_srt4_result_fix;

    logic       clk;
    logic       rst;
    logic       beginSignal;
    logic [7:0] qp, qn, divisor;
    logic [8:0] rem;
    logic [2:0] shift_cnt;
    logic [7:0] outbus;
    logic       outValid;
    logic       endSignal;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    int         v_cyc[$];
    logic [7:0] v_dat[$];
    int         e_cyc[$];

    srt4_result_fix dut (
        .clk         (clk),
        .rst         (rst),
        .beginSignal (beginSignal),
        .qp          (qp),
        .qn          (qn),
        .rem         (rem),
        .divisor     (divisor),
        .shift_cnt   (shift_cnt),
        .outbus      (outbus),
        .outValid    (outValid),
        .endSignal   (endSignal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result byte and completion pulse with the cycle it appeared in.
    always @(negedge clk) begin
        if (outValid) begin
            v_cyc.push_back(cyc);
            v_dat.push_back(outbus);
        end
        if (endSignal) e_cyc.push_back(cyc);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_random_inputs();
        qp        = 8'($urandom);
        qn        = 8'($urandom);
        rem       = 9'($urandom);
        divisor   = 8'($urandom);
        shift_cnt = 3'($urandom);
    endtask

    // Called at a falling edge. Latencies count the start cycle as cycle 1,
    // so the OUTQ cycle is start + (5 + s) - 1 in raw cycle numbers.
    task automatic run_op(input string tag, input logic [7:0] a_qp, input logic [7:0] a_qn,
                          input logic [8:0] a_rem, input logic [7:0] a_dv,
                          input logic [2:0] a_s, input bit pulse_sub, input bit pulse_done);
        int  c;
        int  s;
        bit  neg;
        int  exp_q;
        int  exp_r;
        s     = int'(a_s);
        neg   = (int'(a_rem) >= 256);
        exp_q = (int'(a_qp) - int'(a_qn) - (neg ? 1 : 0)) & 255;
        exp_r = (((int'(a_rem) + (neg ? int'(a_dv) : 0)) % 512) / (1 << s)) & 255;
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
        c = cyc;
        for (int k = 0; k < 20 + s; k++) begin
            if (k == 0) begin
                qp = a_qp; qn = a_qn; rem = a_rem; divisor = a_dv; shift_cnt = a_s;
            end else begin
                drive_random_inputs();
            end
            beginSignal = (k == 0) || (pulse_sub && k == 1) || (pulse_done && k == 6 + s);
            @(negedge clk);
        end
        beginSignal = 1'b0;
        check({tag, " nvalid"}, v_cyc.size(), 2);
        check({tag, " nend"}, e_cyc.size(), 1);
        if (v_cyc.size() >= 1) begin
            check({tag, " outq"}, int'(v_dat[0]), exp_q);
            check({tag, " outq_cyc"}, v_cyc[0] - c + 1, 5 + s);
        end
        if (v_cyc.size() >= 2) begin
            check({tag, " outr"}, int'(v_dat[1]), exp_r);
            check({tag, " outr_cyc"}, v_cyc[1] - c + 1, 6 + s);
        end
        if (e_cyc.size() >= 1) check({tag, " end_cyc"}, e_cyc[0] - c + 1, 7 + s);
    endtask

    initial begin
        rst = 1'b1;
        beginSignal = 1'b0;
        qp = '0; qn = '0; rem = '0; divisor = '0; shift_cnt = '0;
        repeat (2) @(negedge clk);
        check("reset outbus", int'(outbus), 0);
        check("reset outValid", int'(outValid), 0);
        check("reset endSignal", int'(endSignal), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("basic", 8'h10, 8'h02, 9'h060, 8'hE0, 3'd5, 1'b0, 1'b0);
        run_op("corr", 8'h10, 8'h01, 9'h1E0, 8'hE0, 3'd5, 1'b0, 1'b0);
        run_op("zero_rem", 8'h05, 8'h00, 9'h000, 8'h80, 3'd0, 1'b0, 1'b0);
        run_op("wrap", 8'h00, 8'h01, 9'h1FF, 8'hFF, 3'd0, 1'b0, 1'b0);
        run_op("repulse", 8'h10, 8'h02, 9'h060, 8'hE0, 3'd5, 1'b1, 1'b1);

        // Abort in DENORM: start with s=5, reset four cycles later.
        v_cyc.delete();
        v_dat.delete();
        e_cyc.delete();
        qp = 8'h10; qn = 8'h01; rem = 9'h1E0; divisor = 8'hE0; shift_cnt = 3'd5;
        beginSignal = 1'b1;
        @(negedge clk);
        beginSignal = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort outbus", int'(outbus), 0);
        check("abort outValid", int'(outValid), 0);
        check("abort endSignal", int'(endSignal), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort nvalid", v_cyc.size(), 0);
        check("abort nend", e_cyc.size(), 0);
        run_op("after_abort", 8'h10, 8'h02, 9'h060, 8'hE0, 3'd5, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 9'($urandom),
                   8'($urandom) | 8'h80, 3'($urandom), i[0], i[1]);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
